// File: rtl/fpga_reset_sequencer.sv
// Board-level reset conditioning for the PULPissimo FPGA top.
// Synchronises the reset button and the clock-lock flag, debounces the
// button, stretches the reset, then releases JTAG TRST a fixed number of
// cycles ahead of the SoC reset. No handshakes: all inputs are level signals
// sampled every ref_clk cycle, and all outputs are plain registers.
module fpga_reset_sequencer #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int STRETCH_CYCLES   = 1024,
    parameter int JTAG_LEAD_CYCLES = 256
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       btn_reset_n_i,
    input  logic       clk_locked_i,
    output logic       soc_reset_n_o,
    output logic       jtag_trst_n_o,
    output logic       reset_active_o,
    output logic [7:0] reset_count_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
    localparam int LD_W = $clog2(JTAG_LEAD_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(JTAG_LEAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_WAIT    = 3'd1,
        S_STRETCH = 3'd2,
        S_LEAD    = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   btn_s;
    logic                   lock_s;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   ok;

    // State register kept under a stable name so checkers can probe it.
    state_t                 state_q;
    state_t                 state_d;
    logic [ST_W-1:0]        st_cnt_q;
    logic [ST_W-1:0]        st_cnt_d;
    logic [LD_W-1:0]        ld_cnt_q;
    logic [LD_W-1:0]        ld_cnt_d;
    logic                   count_inc;

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign ok     = btn_db & lock_s;

    // Shift both asynchronous inputs through their synchroniser chains.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_reset_n_i};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
        end
    end

    // Debounce: flip btn_db only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            btn_db   <= 1'b0;
            db_cnt_q <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db   <= btn_s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // Sequencer next-state, phase counters and reset-event detection.
    always_comb begin
        state_d   = state_q;
        st_cnt_d  = '0;
        ld_cnt_d  = '0;
        count_inc = 1'b0;
        case (state_q)
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (ok) state_d = S_STRETCH;
            end
            S_STRETCH: begin
                if (!ok)                        state_d = S_WAIT;
                else if (st_cnt_q == ST_LAST)   state_d = S_LEAD;
                else                            st_cnt_d = st_cnt_q + 1'b1;
            end
            S_LEAD: begin
                if (!ok)                        state_d = S_WAIT;
                else if (ld_cnt_q == LD_LAST)   state_d = S_RUN;
                else                            ld_cnt_d = ld_cnt_q + 1'b1;
            end
            S_RUN: begin
                if (!ok) begin
                    state_d   = S_WAIT;
                    count_inc = (reset_count_o != 8'hFF);
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they
    // move on the same edge as the transition that causes them.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HOLD;
            st_cnt_q       <= '0;
            ld_cnt_q       <= '0;
            soc_reset_n_o  <= 1'b0;
            jtag_trst_n_o  <= 1'b0;
            reset_active_o <= 1'b1;
            reset_count_o  <= 8'd0;
        end else begin
            state_q        <= state_d;
            st_cnt_q       <= st_cnt_d;
            ld_cnt_q       <= ld_cnt_d;
            soc_reset_n_o  <= (state_d == S_RUN);
            jtag_trst_n_o  <= (state_d == S_LEAD) || (state_d == S_RUN);
            reset_active_o <= (state_d != S_RUN);
            if (count_inc) reset_count_o <= reset_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Testbench for fpga_reset_sequencer. The reference model works on input
// histories and the length of the current run of "ok" samples rather than
// on a state machine: JTAG is released once ok has held for STRETCH+1
// consecutive edges, the SoC once it has held for STRETCH+LEAD+1 edges, and a
// reset event is counted whenever such a fully released run ends.
module tb_fpga_reset_sequencer;

  localparam int SY = 2;
  localparam int D  = 4;
  localparam int S  = 8;
  localparam int J  = 4;

  // ---------------- clock / reset ----------------
  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic       lock = 1'b1;
  logic       soc_reset_n;
  logic       jtag_trst_n;
  logic       reset_active;
  logic [7:0] reset_count;

  always #5 ref_clk = ~ref_clk;

  fpga_reset_sequencer #(
    .SYNC_STAGES      (SY),
    .DEBOUNCE_CYCLES  (D),
    .STRETCH_CYCLES   (S),
    .JTAG_LEAD_CYCLES (J)
  ) dut (
    .ref_clk        (ref_clk),
    .rst            (rst),
    .btn_reset_n_i  (btn),
    .clk_locked_i   (lock),
    .soc_reset_n_o  (soc_reset_n),
    .jtag_trst_n_o  (jtag_trst_n),
    .reset_active_o (reset_active),
    .reset_count_o  (reset_count)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [10:0] exp_q[$];

  bit b_in[$];
  bit l_in[$];
  bit bs_hist[$];
  bit db_m;
  int run_m;
  int cnt_m;
  int t_m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    b_in.delete();
    l_in.delete();
    bs_hist.delete();
    exp_q.delete();
    db_m  = 1'b0;
    run_m = 0;
    cnt_m = 0;
    t_m   = 0;
  endtask

  // One rising edge: b/l are the raw input levels present at this edge.
  task automatic model_edge(input bit b, input bit l);
    int idx;
    bit bs;
    bit ls;
    bit ok;
    bit all_diff;
    idx = t_m - SY;
    bs  = (idx >= 0) ? b_in[idx] : 1'b0;
    ls  = (idx >= 0) ? l_in[idx] : 1'b0;
    ok  = db_m & ls;
    if (ok) begin
      run_m++;
    end else begin
      if (run_m >= S + J + 1 && cnt_m < 255) cnt_m++;
      run_m = 0;
    end
    bs_hist.push_back(bs);
    if (bs_hist.size() > D) void'(bs_hist.pop_front());
    if (bs_hist.size() == D) begin
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (bs_hist[i] == db_m) all_diff = 1'b0;
      if (all_diff) begin
        db_m = ~db_m;
        bs_hist.delete();
      end
    end
    b_in.push_back(b);
    l_in.push_back(l);
    t_m++;
    exp_q.push_back({8'(cnt_m), (run_m < S + J + 1), (run_m >= S + J + 1), (run_m >= S + 1)});
  endtask

  task automatic check_outputs(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    check({tag, ".jtag"},   {7'd0, jtag_trst_n},  {7'd0, e[0]});
    check({tag, ".soc"},    {7'd0, soc_reset_n},  {7'd0, e[1]});
    check({tag, ".active"}, {7'd0, reset_active}, {7'd0, e[2]});
    check({tag, ".count"},  reset_count,          e[10:3]);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit b, input bit l, input string tag);
    @(negedge ref_clk);
    btn  = b;
    lock = l;
    @(posedge ref_clk);
    model_edge(b, l);
    #1 check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".jtag"},   {7'd0, jtag_trst_n},  8'd0);
    check({tag, ".soc"},    {7'd0, soc_reset_n},  8'd0);
    check({tag, ".active"}, {7'd0, reset_active}, 8'd1);
    check({tag, ".count"},  reset_count,          8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    bit rb;
    bit rl;
    int len;

    model_reset();

    // 1. power-up: rst for 5 cycles, button released, lock present
    repeat (5) @(posedge ref_clk);
    #1 check_reset_values("por");
    #1 rst = 1'b0;
    repeat (30) step(1'b1, 1'b1, "pwrup");
    check("pwrup_run", {7'd0, soc_reset_n}, 8'd1);

    // 2. three-cycle button glitch in RUN is ignored
    repeat (3)  step(1'b0, 1'b1, "glitch");
    repeat (10) step(1'b1, 1'b1, "glitch_after");

    // 3. real press for 10 cycles, then release and re-sequence
    repeat (10) step(1'b0, 1'b1, "press");
    repeat (30) step(1'b1, 1'b1, "release");
    check("press_count", reset_count, 8'd1);

    // 4. lock lost during LEAD: TRST reasserted, full stretch afterwards
    step(1'b1, 1'b0, "lead_prep");
    k = 0;
    while (run_m != S + 1 && k < 60) begin
      step(1'b1, 1'b1, "to_lead");
      k++;
    end
    check("lead_reached", {7'd0, jtag_trst_n}, 8'd1);
    repeat (3)  step(1'b1, 1'b0, "lead_abort");
    check("lead_abort_trst", {7'd0, jtag_trst_n}, 8'd0);
    repeat (25) step(1'b1, 1'b1, "lead_resume");

    // 5. 260 exits from RUN: counter saturates at 255
    for (int e = 0; e < 260; e++) begin
      step(1'b1, 1'b0, "sat_drop");
      repeat (S + J + 3) step(1'b1, 1'b1, "sat_run");
    end
    check("sat_count", reset_count, 8'd255);

    // asynchronous rst in the middle of STRETCH
    step(1'b1, 1'b0, "mid_prep");
    k = 0;
    while (run_m != 4 && k < 30) begin
      step(1'b1, 1'b1, "to_stretch");
      k++;
    end
    rst = 1'b1;
    #1 check_reset_values("async_rst");
    repeat (2) @(posedge ref_clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (25) step(1'b1, 1'b1, "post_rst");

    // randomized segments of button / lock levels
    for (int seg = 0; seg < 60; seg++) begin
      rb  = ($urandom_range(0, 9) < 8);
      rl  = ($urandom_range(0, 9) < 8);
      len = (rb && rl) ? $urandom_range(1, 25) : $urandom_range(1, 7);
      repeat (len) step(rb, rl, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
